// File: rtl/strassen_pkg.sv
// Shared types, width helpers and the Strassen recombination sign table.
package strassen_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_MUL,
    S_ACC,
    S_DONE
  } state_t;

  // Operand width: an unsigned element plus room for a quadrant sum or difference.
  function automatic int calc_ow(input int ew);
    return ew + 2;
  endfunction

  // Accumulator width: full operand product plus growth over the inner sum and recombination.
  function automatic int calc_aw(input int ew, input int n);
    return 2 * calc_ow(ew) + $clog2(n) + 3;
  endfunction

  // Sign codes for adding Mk into a C quadrant.
  localparam logic [1:0] SG_ZERO = 2'b00;
  localparam logic [1:0] SG_POS  = 2'b01;
  localparam logic [1:0] SG_NEG  = 2'b11;

  // Per product k (M1..M7), sign applied to quadrants in order C11, C12, C21, C22.
  localparam logic [1:0] SIGN_TBL [7][4] = '{
    '{SG_POS,  SG_ZERO, SG_ZERO, SG_POS },  // M1
    '{SG_ZERO, SG_ZERO, SG_POS,  SG_NEG },  // M2
    '{SG_ZERO, SG_POS,  SG_ZERO, SG_POS },  // M3
    '{SG_POS,  SG_ZERO, SG_POS,  SG_ZERO},  // M4
    '{SG_NEG,  SG_POS,  SG_ZERO, SG_ZERO},  // M5
    '{SG_ZERO, SG_ZERO, SG_ZERO, SG_POS },  // M6
    '{SG_POS,  SG_ZERO, SG_ZERO, SG_ZERO}   // M7
  };

endpackage

// File: rtl/strassen_matmul_if.sv
// Operand/result bus between the matrix memories and the MAC datapath.
// Protocol: no backpressure; when en is high the MAC consumes the eight quadrant
// elements in that cycle, clear restarts the sum, and acc reflects all consumed products.
interface strassen_matmul_if #(
  parameter int EW = 8,
  parameter int AW = 25
);
  logic [2:0]    k;
  logic          en;
  logic          clear;
  logic [EW-1:0] a11, a12, a21, a22;
  logic [EW-1:0] b11, b12, b21, b22;
  logic [AW-1:0] acc;

  modport master (
    output k, en, clear, a11, a12, a21, a22, b11, b12, b21, b22,
    input  acc
  );

  modport slave (
    input  k, en, clear, a11, a12, a21, a22, b11, b12, b21, b22,
    output acc
  );
endinterface

// File: rtl/strassen_mac_unit.sv
// Builds the two Strassen operands for product k and accumulates their product.
module strassen_mac_unit
  import strassen_pkg::*;
#(
  parameter int EW = 8,
  parameter int AW = calc_aw(8, 256)
) (
  input logic               clk,
  input logic               rst,
  strassen_matmul_if.slave  mac_bus
);
  localparam int OW = calc_ow(EW);

  logic signed [OW-1:0]   a11, a12, a21, a22, b11, b12, b21, b22;
  logic signed [OW-1:0]   lhs, rhs;
  logic signed [2*OW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW-1:0]   acc_r;

  assign a11 = $signed({2'b00, mac_bus.a11});
  assign a12 = $signed({2'b00, mac_bus.a12});
  assign a21 = $signed({2'b00, mac_bus.a21});
  assign a22 = $signed({2'b00, mac_bus.a22});
  assign b11 = $signed({2'b00, mac_bus.b11});
  assign b12 = $signed({2'b00, mac_bus.b12});
  assign b21 = $signed({2'b00, mac_bus.b21});
  assign b22 = $signed({2'b00, mac_bus.b22});

  // Select the left/right operand combination for the current product.
  always_comb begin
    lhs = '0;
    rhs = '0;
    case (mac_bus.k)
      3'd0: begin lhs = a11 + a22; rhs = b11 + b22; end
      3'd1: begin lhs = a21 + a22; rhs = b11;       end
      3'd2: begin lhs = a11;       rhs = b12 - b22; end
      3'd3: begin lhs = a22;       rhs = b21 - b11; end
      3'd4: begin lhs = a11 + a12; rhs = b22;       end
      3'd5: begin lhs = a21 - a11; rhs = b11 + b12; end
      3'd6: begin lhs = a12 - a22; rhs = b21 + b22; end
      default: begin lhs = '0; rhs = '0; end
    endcase
  end

  assign prod     = lhs * rhs;
  assign prod_ext = {{(AW - 2*OW){prod[2*OW-1]}}, prod};

  // Accumulate one product per enabled cycle; clear restarts the sum with this product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (mac_bus.en) begin
      acc_r <= (mac_bus.clear ? '0 : acc_r) + prod_ext;
    end
  end

  assign mac_bus.acc = acc_r;

endmodule

// File: rtl/strassen_matmul_top.sv
// Single-level Strassen multiplier: fills A/B from generators, runs M1..M7 on one MAC,
// recombines each Mk element into C, then holds done_final.
module strassen_matmul_top
  import strassen_pkg::*;
#(
  parameter int MAT_A_SIZE    = 256,
  parameter int MAT_B_SIZE    = 256,
  parameter int ELEM_BITWIDTH = 8
) (
  input  logic fast_clk,
  input  logic rst,
  output logic done_final
);
  localparam int N  = MAT_A_SIZE;
  localparam int H  = N / 2;
  localparam int NB = $clog2(N);
  localparam int EW = ELEM_BITWIDTH;
  localparam int AW = calc_aw(EW, N);

  localparam logic [NB-1:0] HOFF = NB'(H);
  localparam logic [NB-1:0] HMAX = NB'(H - 1);
  localparam logic [NB-1:0] NMAX = NB'(N - 1);

  if (MAT_B_SIZE != MAT_A_SIZE) begin : g_size_check
    $error("strassen_matmul_top: MAT_B_SIZE must equal MAT_A_SIZE");
  end
  if (N < 2 || (N & (N - 1)) != 0) begin : g_pow2_check
    $error("strassen_matmul_top: MAT_A_SIZE must be a power of two >= 2");
  end

  state_t        state;
  logic [2:0]    k;
  logic [NB-1:0] r, c, t;
  logic [NB-1:0] ii, jj;

  logic [EW-1:0] a_mem [N][N];
  logic [EW-1:0] b_mem [N][N];
  logic [AW-1:0] c_mem [N][N];

  logic [31:0]   ii_w, jj_w;
  logic [EW-1:0] gen_a, gen_b;

  strassen_matmul_if #(.EW(EW), .AW(AW)) mac_bus ();

  // Generator values for the element being initialised; truncation is the mask.
  assign ii_w  = 32'(ii);
  assign jj_w  = 32'(jj);
  assign gen_a = EW'(ii_w + jj_w);
  assign gen_b = EW'(ii_w * jj_w + 32'd1);

  // Quadrant reads: lhs element [r][t], rhs element [t][c]; upper halves offset by H.
  assign mac_bus.k     = k;
  assign mac_bus.en    = (state == S_MUL);
  assign mac_bus.clear = (t == '0);
  assign mac_bus.a11   = a_mem[r][t];
  assign mac_bus.a12   = a_mem[r][t + HOFF];
  assign mac_bus.a21   = a_mem[r + HOFF][t];
  assign mac_bus.a22   = a_mem[r + HOFF][t + HOFF];
  assign mac_bus.b11   = b_mem[t][c];
  assign mac_bus.b12   = b_mem[t][c + HOFF];
  assign mac_bus.b21   = b_mem[t + HOFF][c];
  assign mac_bus.b22   = b_mem[t + HOFF][c + HOFF];

  strassen_mac_unit #(.EW(EW), .AW(AW)) u_mac (
    .clk     (fast_clk),
    .rst     (rst),
    .mac_bus (mac_bus)
  );

  function automatic logic [AW-1:0] apply_sign(
    input logic [AW-1:0] old_v,
    input logic [1:0]    sg,
    input logic [AW-1:0] v
  );
    case (sg)
      SG_POS:  return old_v + v;
      SG_NEG:  return old_v - v;
      default: return old_v;
    endcase
  endfunction

  // Sequencer: init sweep, then per (k, r, c) H MAC cycles plus one recombination cycle.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      done_final <= 1'b0;
      k          <= '0;
      r          <= '0;
      c          <= '0;
      t          <= '0;
      ii         <= '0;
      jj         <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (jj == NMAX) begin
            jj <= '0;
            if (ii == NMAX) begin
              ii    <= '0;
              k     <= '0;
              r     <= '0;
              c     <= '0;
              t     <= '0;
              state <= S_MUL;
            end else begin
              ii <= ii + 1'b1;
            end
          end else begin
            jj <= jj + 1'b1;
          end
        end
        S_MUL: begin
          if (t == HMAX) begin
            t     <= '0;
            state <= S_ACC;
          end else begin
            t <= t + 1'b1;
          end
        end
        S_ACC: begin
          state <= S_MUL;
          if (c == HMAX) begin
            c <= '0;
            if (r == HMAX) begin
              r <= '0;
              if (k == 3'd6) begin
                state      <= S_DONE;
                done_final <= 1'b1;
              end else begin
                k <= k + 1'b1;
              end
            end else begin
              r <= r + 1'b1;
            end
          end else begin
            c <= c + 1'b1;
          end
        end
        S_DONE: begin
          done_final <= 1'b1;
        end
        default: begin
          state <= S_INIT;
        end
      endcase
    end
  end

  // Memory writes: generator fill during init, Mk recombination into C quadrants on S_ACC.
  always_ff @(posedge fast_clk) begin
    if (state == S_INIT) begin
      a_mem[ii][jj] <= gen_a;
      b_mem[ii][jj] <= gen_b;
      c_mem[ii][jj] <= '0;
    end else if (state == S_ACC) begin
      c_mem[r][c]               <= apply_sign(c_mem[r][c],               SIGN_TBL[k][0], mac_bus.acc);
      c_mem[r][c + HOFF]        <= apply_sign(c_mem[r][c + HOFF],        SIGN_TBL[k][1], mac_bus.acc);
      c_mem[r + HOFF][c]        <= apply_sign(c_mem[r + HOFF][c],        SIGN_TBL[k][2], mac_bus.acc);
      c_mem[r + HOFF][c + HOFF] <= apply_sign(c_mem[r + HOFF][c + HOFF], SIGN_TBL[k][3], mac_bus.acc);
    end
  end

endmodule

// File: tb/tb_strassen_matmul_top.sv
// Bench for strassen_matmul_top at N=2, N=4 and N=8 (4-bit elements).
module tb_strassen_matmul_top;

  // Clock and resets
  logic fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  logic rst_n2 = 1'b1;
  logic rst_n4 = 1'b1;
  logic rst_n8 = 1'b1;
  logic done_n2, done_n4, done_n8;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  strassen_matmul_top #(.MAT_A_SIZE(2), .MAT_B_SIZE(2), .ELEM_BITWIDTH(8)) u_n2 (
    .fast_clk(fast_clk), .rst(rst_n2), .done_final(done_n2));
  strassen_matmul_top #(.MAT_A_SIZE(4), .MAT_B_SIZE(4), .ELEM_BITWIDTH(8)) u_n4 (
    .fast_clk(fast_clk), .rst(rst_n4), .done_final(done_n4));
  strassen_matmul_top #(.MAT_A_SIZE(8), .MAT_B_SIZE(8), .ELEM_BITWIDTH(4)) u_n8 (
    .fast_clk(fast_clk), .rst(rst_n8), .done_final(done_n8));

  // Scoreboard check
  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Naive reference product with masked generator inputs.
  function automatic longint ref_c(input int n, input int ew, input int i, input int j);
    longint s;
    int mask;
    mask = (1 << ew) - 1;
    s = 0;
    for (int tt = 0; tt < n; tt++) begin
      s += longint'((i + tt) & mask) * longint'((tt * j + 1) & mask);
    end
    return s;
  endfunction

  function automatic logic sel_done(input int which);
    case (which)
      2:       return done_n2;
      4:       return done_n4;
      default: return done_n8;
    endcase
  endfunction

  // Driver: count rising edges after reset release until done_final, bounded.
  task automatic wait_done(input int which, input int bound, output int cyc);
    cyc = -1;
    for (int i = 1; i <= bound; i++) begin
      @(posedge fast_clk);
      #1;
      if (sel_done(which)) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check_n2_hand(input string tag);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd2);
    exp_q.push_back(64'd3);
    exp_q.push_back(64'd5);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        check_val($sformatf("%s_c%0d%0d", tag, i, j),
                  longint'(u_n2.c_mem[1'(i)][1'(j)]), longint'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic check_n4_all(input string tag);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        exp_q.push_back(64'(ref_c(4, 8, i, j)));
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        check_val($sformatf("%s_c%0d%0d", tag, i, j),
                  longint'(u_n4.c_mem[2'(i)][2'(j)]), longint'(exp_q.pop_front()));
      end
    end
  endtask

  task automatic check_n8_all(input string tag);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        exp_q.push_back(64'(ref_c(8, 4, i, j)));
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        check_val($sformatf("%s_c%0d%0d", tag, i, j),
                  longint'(u_n8.c_mem[3'(i)][3'(j)]), longint'(exp_q.pop_front()));
      end
    end
  endtask

  initial begin
    int cyc;

    // Reset held: done_final low on every instance.
    repeat (3) begin
      @(negedge fast_clk);
      check_val("reset_done_n2", longint'(done_n2), 0);
      check_val("reset_done_n4", longint'(done_n4), 0);
      check_val("reset_done_n8", longint'(done_n8), 0);
    end

    // N=2: latency 4 + 7*1*2 = 18, C = {{1,2},{3,5}}.
    rst_n2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge fast_clk);
      #1;
      check_val("init_done_n2", longint'(done_n2), 0);
    end
    wait_done(2, 200, cyc);
    check_val("latency_n2", longint'(cyc + 4), 18);
    check_n2_hand("n2");

    // Hold after done: done stays high, C unchanged.
    for (int i = 0; i < 100; i++) begin
      @(posedge fast_clk);
      #1;
      if (i % 25 == 0) check_val("hold_done_n2", longint'(done_n2), 1);
    end
    check_val("hold_done_n2_end", longint'(done_n2), 1);
    check_n2_hand("n2_hold");

    // N=4: latency 16 + 7*4*3 = 100, corner values hand-computed, full reference.
    @(negedge fast_clk);
    rst_n4 = 1'b0;
    wait_done(4, 1000, cyc);
    check_val("latency_n4", longint'(cyc), 100);
    check_val("n4_c00_hand", longint'(u_n4.c_mem[2'd0][2'd0]), 6);
    check_val("n4_c33_hand", longint'(u_n4.c_mem[2'd3][2'd3]), 114);
    check_n4_all("n4");

    // Reset while done: done_final drops immediately.
    @(negedge fast_clk);
    rst_n4 = 1'b1;
    #1;
    check_val("rst_drop_n4", longint'(done_n4), 0);
    @(negedge fast_clk);
    rst_n4 = 1'b0;
    // Run into S_MUL, then a one-cycle reset pulse mid-computation.
    repeat (40) @(posedge fast_clk);
    @(negedge fast_clk);
    check_val("mid_mul_done_n4", longint'(done_n4), 0);
    rst_n4 = 1'b1;
    #1;
    check_val("mid_rst_done_n4", longint'(done_n4), 0);
    @(negedge fast_clk);
    rst_n4 = 1'b0;
    wait_done(4, 1000, cyc);
    check_val("latency_n4_restart", longint'(cyc), 100);
    check_n4_all("n4_restart");

    // N=8, 4-bit elements: generator wrap, latency 64 + 7*16*5 = 624.
    @(negedge fast_clk);
    rst_n8 = 1'b0;
    wait_done(8, 2000, cyc);
    check_val("latency_n8", longint'(cyc), 624);
    check_n8_all("n8");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
